// File: rtl/rasfic_pkg.sv
// rasfic_pkg
//   Constants and types shared by the FIC<->host nibble link blocks
//   (32-to-4 transmitter and 4-to-32 receiver).
//   NIBBLE_W : link data width
//   WORD_W   : word width on the wide side (multiple of NIBBLE_W)
//   NPW      : nibbles per word
//   CNT_W    : width of the nibble slot counter
package rasfic_pkg;

  localparam int NIBBLE_W = 4;
  localparam int WORD_W   = 32;
  localparam int NPW      = WORD_W / NIBBLE_W;
  localparam int CNT_W    = (NPW > 1) ? $clog2(NPW) : 1;

  // Start/run control: the block leaves IDLE on the first sampled ap_start
  // and stays in RUN until reset.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/rasfic_rx4to32.sv
// rasfic_rx4to32
//   Reassembles the little-endian nibble stream produced by the 32-to-4
//   transmitter into WORD_W-bit words. The first nibble of a word lands in
//   bits [NIBBLE_W-1:0].
//
//   Ports
//     ap_clk, ap_rst_n   clock, asynchronous active-low reset
//     ap_start           level; first sampled high starts the block
//     ap_idle            high until ap_start has been seen
//     input_r_T*         nibble AXI-Stream sink
//     output_r_T*        word AXI-Stream source
//     word_count         number of output handshakes (wraps)
//
//   Handshakes: a transfer happens on a rising edge where VALID and READY
//   are both high. A source never drops VALID or changes DATA while waiting
//   for READY. input_r_TREADY is driven from registers only.
//
//   Buffering: one output slot plus the assembly register. When a word
//   completes while the output slot is stalled, the word parks in the
//   assembly register (asm_full) and input is held off until it drains.
module rasfic_rx4to32 #(
  parameter int NIBBLE_W = rasfic_pkg::NIBBLE_W,
  parameter int WORD_W   = rasfic_pkg::WORD_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_idle,
  input  logic                input_r_TVALID,
  output logic                input_r_TREADY,
  input  logic [NIBBLE_W-1:0] input_r_TDATA,
  output logic                output_r_TVALID,
  input  logic                output_r_TREADY,
  output logic [WORD_W-1:0]   output_r_TDATA,
  output logic [31:0]         word_count
);
  import rasfic_pkg::*;

  localparam int NPW   = WORD_W / NIBBLE_W;
  localparam int CNT_W = (NPW > 1) ? $clog2(NPW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPW - 1);

  // ---------------------------------------------------------------------
  // Run control FSM
  // ---------------------------------------------------------------------
  run_state_e state;
  run_state_e state_nxt;
  logic       running;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ap_start) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
    ap_idle = (state != ST_RUN);
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] asm_q;
  logic              asm_full;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic [31:0]       out_count;

  logic              in_hs;
  logic              out_hs;
  logic              word_done;
  logic              direct_load;
  logic [WORD_W-1:0] merged;

  assign input_r_TREADY  = running && !asm_full;
  assign output_r_TVALID = out_valid;
  assign output_r_TDATA  = out_data;
  assign word_count      = out_count;

  assign in_hs     = input_r_TVALID && input_r_TREADY;
  assign out_hs    = out_valid && output_r_TREADY;
  assign word_done = in_hs && (cnt == CNT_LAST);
  // The completed word bypasses the assembly register when the output slot
  // is free or is being emptied on this very edge.
  assign direct_load = word_done && (!out_valid || out_hs);

  // Assembly register with the current nibble dropped into slot cnt.
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < NPW; k++) begin
      if (cnt == CNT_W'(k)) merged[k*NIBBLE_W +: NIBBLE_W] = input_r_TDATA;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt       <= '0;
      asm_q     <= '0;
      asm_full  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      if (in_hs) begin
        cnt <= word_done ? '0 : cnt + CNT_W'(1);
        if (!direct_load) asm_q <= merged;
      end

      // asm_full only sets when input is accepted, which requires it clear,
      // so the set and clear branches never compete.
      if (word_done && !direct_load) asm_full <= 1'b1;
      else if (out_hs && asm_full)   asm_full <= 1'b0;

      if (direct_load) begin
        out_data  <= merged;
        out_valid <= 1'b1;
      end else if (out_hs && asm_full) begin
        out_data  <= asm_q;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      if (out_hs) out_count <= out_count + 32'd1;
    end
  end

endmodule
